// File: rtl/jaa_pkg.sv
// Shared definitions for the Java-to-ARM fetch front end: opcode constants,
// sequencer state encoding and the operand-length lookup.
package jaa_pkg;

    localparam logic [7:0] OP_ICONST_0 = 8'h03;
    localparam logic [7:0] OP_ICONST_5 = 8'h08;
    localparam logic [7:0] OP_BIPUSH   = 8'h10;
    localparam logic [7:0] OP_SIPUSH   = 8'h11;
    localparam logic [7:0] OP_ILOAD    = 8'h15;
    localparam logic [7:0] OP_ILOAD_0  = 8'h1A;
    localparam logic [7:0] OP_ILOAD_3  = 8'h1D;
    localparam logic [7:0] OP_ISTORE   = 8'h36;
    localparam logic [7:0] OP_ISTORE_0 = 8'h3B;
    localparam logic [7:0] OP_ISTORE_3 = 8'h3E;
    localparam logic [7:0] OP_DUP_LO   = 8'h59;
    localparam logic [7:0] OP_DUP_HI   = 8'h5E;
    localparam logic [7:0] OP_IADD     = 8'h60;
    localparam logic [7:0] OP_GOTO     = 8'hA7;
    localparam logic [7:0] OP_WIDE     = 8'hC4;

    typedef enum logic [1:0] {
        ST_OPCODE = 2'd0,
        ST_OPER1  = 2'd1,
        ST_OPER2  = 2'd2,
        ST_ISSUE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [1:0] len;
        logic       unsup;
    } len_info_t;

    // A wide prefix only legitimises the local-variable load/store forms.
    function automatic len_info_t opcode_len(input logic [7:0] opcode, input logic wide);
        len_info_t r;
        r.len   = 2'd0;
        r.unsup = 1'b0;
        if (wide) begin
            if (opcode == OP_ILOAD || opcode == OP_ISTORE) r.len = 2'd2;
            else r.unsup = 1'b1;
        end else if ((opcode >= OP_ICONST_0 && opcode <= OP_ICONST_5) ||
                     (opcode >= OP_ILOAD_0  && opcode <= OP_ILOAD_3)  ||
                     (opcode >= OP_ISTORE_0 && opcode <= OP_ISTORE_3) ||
                     (opcode >= OP_DUP_LO   && opcode <= OP_DUP_HI)   ||
                     (opcode == OP_IADD)) begin
            r.len = 2'd0;
        end else if (opcode == OP_BIPUSH || opcode == OP_ILOAD || opcode == OP_ISTORE) begin
            r.len = 2'd1;
        end else if (opcode == OP_SIPUSH || opcode == OP_GOTO) begin
            r.len = 2'd2;
        end else begin
            r.unsup = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/jaa_opcode_len.sv
// Combinational operand-count decoder: opcode (plus pending wide prefix) to
// operand length and unsupported flag.
module jaa_opcode_len
    import jaa_pkg::*;
(
    input  logic [7:0] opcode,
    input  logic       wide,
    output logic [1:0] len,
    output logic       unsup
);

    len_info_t info;

    always_comb begin
        info  = opcode_len(opcode, wide);
        len   = info.len;
        unsup = info.unsup;
    end

endmodule

// File: rtl/jaa_fetch_sequencer.sv
// Bytecode fetch sequencer: gathers opcode + operands into one PC-tagged bundle
// and holds it on a valid/ready port. Define JAA_WIDE_EN to honour the wide prefix.
module jaa_fetch_sequencer
    import jaa_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             insn_valid,
    input  logic             insn_ready,
    output logic [7:0]       insn_opcode,
    output logic [7:0]       insn_op1,
    output logic [7:0]       insn_op2,
    output logic [1:0]       insn_len,
    output logic             insn_unsup,
    output logic             insn_wide,
    output logic [PC_W-1:0]  insn_pc,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] unsup_cnt
);

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d, insn_pc_q, insn_pc_d;
    logic [7:0]       opcode_q, opcode_d, op1_q, op1_d, op2_q, op2_d;
    logic [1:0]       len_q, len_d;
    logic             unsup_q, unsup_d, wide_q, wide_d, wide_pend_q, wide_pend_d;
    logic [CNT_W-1:0] issued_q, issued_d, unsup_cnt_q, unsup_cnt_d;
    logic [1:0]       lk_len;
    logic             lk_unsup;
    logic             fetching, byte_xfer, is_prefix;

    jaa_opcode_len u_len (
        .opcode (byte_data),
        .wide   (wide_pend_q),
        .len    (lk_len),
        .unsup  (lk_unsup)
    );

`ifdef JAA_WIDE_EN
    // A second 0xC4 after a prefix is decoded as an (unsupported) opcode.
    assign is_prefix = (byte_data == OP_WIDE) && !wide_pend_q;
`else
    assign is_prefix = 1'b0;
`endif

    assign fetching   = (state_q != ST_ISSUE);
    assign byte_xfer  = byte_valid && fetching;
    assign byte_ready = reset_n && fetching;
    assign insn_valid = (state_q == ST_ISSUE);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        insn_pc_d   = insn_pc_q;
        opcode_d    = opcode_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        len_d       = len_q;
        unsup_d     = unsup_q;
        wide_d      = wide_q;
        wide_pend_d = wide_pend_q;
        issued_d    = issued_q;
        unsup_cnt_d = unsup_cnt_q;
        if (byte_xfer) pc_d = pc_q + 1'b1;
        case (state_q)
            ST_OPCODE: begin
                if (byte_xfer) begin
                    if (is_prefix) begin
                        wide_pend_d = 1'b1;
                        insn_pc_d   = pc_q;
                    end else begin
                        opcode_d    = byte_data;
                        op1_d       = 8'd0;
                        op2_d       = 8'd0;
                        len_d       = lk_len;
                        unsup_d     = lk_unsup;
                        wide_d      = wide_pend_q;
                        wide_pend_d = 1'b0;
                        if (!wide_pend_q) insn_pc_d = pc_q;
                        state_d     = (lk_len == 2'd0) ? ST_ISSUE : ST_OPER1;
                    end
                end
            end
            ST_OPER1: begin
                if (byte_xfer) begin
                    op1_d   = byte_data;
                    state_d = (len_q == 2'd1) ? ST_ISSUE : ST_OPER2;
                end
            end
            ST_OPER2: begin
                if (byte_xfer) begin
                    op2_d   = byte_data;
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                if (insn_ready) begin
                    state_d  = ST_OPCODE;
                    issued_d = (issued_q == '1) ? issued_q : issued_q + 1'b1;
                    if (unsup_q)
                        unsup_cnt_d = (unsup_cnt_q == '1) ? unsup_cnt_q : unsup_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_OPCODE;
            pc_q        <= '0;
            insn_pc_q   <= '0;
            opcode_q    <= 8'd0;
            op1_q       <= 8'd0;
            op2_q       <= 8'd0;
            len_q       <= 2'd0;
            unsup_q     <= 1'b0;
            wide_q      <= 1'b0;
            wide_pend_q <= 1'b0;
            issued_q    <= '0;
            unsup_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            insn_pc_q   <= insn_pc_d;
            opcode_q    <= opcode_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            len_q       <= len_d;
            unsup_q     <= unsup_d;
            wide_q      <= wide_d;
            wide_pend_q <= wide_pend_d;
            issued_q    <= issued_d;
            unsup_cnt_q <= unsup_cnt_d;
        end
    end

    assign insn_opcode = opcode_q;
    assign insn_op1    = op1_q;
    assign insn_op2    = op2_q;
    assign insn_len    = len_q;
    assign insn_unsup  = unsup_q;
    assign insn_wide   = wide_q;
    assign insn_pc     = insn_pc_q;
    assign issued_cnt  = issued_q;
    assign unsup_cnt   = unsup_cnt_q;

endmodule

// File: tb/tb_jaa_fetch_sequencer.sv
// Bench for jaa_fetch_sequencer: directed scenarios then a randomized byte stream
// checked against a stream-parsing reference model. Honours JAA_WIDE_EN.
module tb_jaa_fetch_sequencer;

    localparam int PC_W  = 5;
    localparam int CNT_W = 4;
    localparam int N     = 400;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [7:0]      op;
        logic [7:0]      o1;
        logic [7:0]      o2;
        logic [1:0]      len;
        logic            unsup;
        logic            wide;
        logic [PC_W-1:0] pc;
    } bundle_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             insn_valid;
    logic             insn_ready;
    logic [7:0]       insn_opcode, insn_op1, insn_op2;
    logic [1:0]       insn_len;
    logic             insn_unsup, insn_wide;
    logic [PC_W-1:0]  insn_pc;
    logic [CNT_W-1:0] issued_cnt, unsup_cnt;

    int checks   = 0;
    int failures = 0;

    jaa_fetch_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .insn_valid  (insn_valid),
        .insn_ready  (insn_ready),
        .insn_opcode (insn_opcode),
        .insn_op1    (insn_op1),
        .insn_op2    (insn_op2),
        .insn_len    (insn_len),
        .insn_unsup  (insn_unsup),
        .insn_wide   (insn_wide),
        .insn_pc     (insn_pc),
        .issued_cnt  (issued_cnt),
        .unsup_cnt   (unsup_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [7:0] op, input logic [7:0] o1, input logic [7:0] o2,
                                       input logic [1:0] ln, input logic un, input logic wd,
                                       input logic [PC_W-1:0] pc);
        bundle_t b;
        b = '{op: op, o1: o1, o2: o2, len: ln, unsup: un, wide: wd, pc: pc};
        return 64'(b);
    endfunction

    function automatic logic [63:0] cur();
        return mk(insn_opcode, insn_op1, insn_op2, insn_len, insn_unsup, insn_wide, insn_pc);
    endfunction

    // Opcode table written straight from the Java opcode list.
    function automatic void ref_len(input logic [7:0] op, input logic wide, output int ln, output logic un);
        un = 1'b0;
        ln = 0;
        if (wide) begin
            if (op == 8'h15 || op == 8'h36) ln = 2;
            else un = 1'b1;
        end else if (op inside {[8'h03:8'h08], [8'h1A:8'h1D], [8'h3B:8'h3E], [8'h59:8'h5E], 8'h60}) ln = 0;
        else if (op inside {8'h10, 8'h15, 8'h36}) ln = 1;
        else if (op inside {8'h11, 8'hA7}) ln = 2;
        else un = 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 50) begin
            tick();
            n++;
        end
        if (!byte_ready) chk("send_timeout", byte_ready, 1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic accept();
        insn_ready = 1'b1;
        tick();
        insn_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        insn_ready = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    logic [7:0]  stream [N];
    logic [7:0]  picks [12];
    bundle_t     exp_q [$];
    bundle_t     eb;
    int          i, pc0, ln, ei, bi, cyc, acc, uacc;
    logic        w, un;
    logic [7:0]  op;

    initial begin
        // reset state
        reset_n    = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        insn_ready = 1'b0;
        #12;
        chk("rst_byte_ready", byte_ready, 0);
        chk("rst_insn_valid", insn_valid, 0);
        chk("rst_bundle", cur(), 0);
        chk("rst_issued", issued_cnt, 0);
        chk("rst_unsup", unsup_cnt, 0);
        do_reset();

        // 1: two zero-operand opcodes, translator always ready
        insn_ready = 1'b1;
        send(8'h04);
        chk("t1_valid", insn_valid, 1);
        chk("t1_b0", cur(), mk(8'h04, 0, 0, 0, 0, 0, 0));
        send(8'h3C);
        chk("t1_b1", cur(), mk(8'h3C, 0, 0, 0, 0, 0, 1));
        tick();
        chk("t1_issued", issued_cnt, 2);

        // 2: one-operand opcode, ready low only during ISSUE
        do_reset();
        insn_ready = 1'b1;
        send(8'h36);
        chk("t2_ready_oper1", byte_ready, 1);
        send(8'h07);
        chk("t2_b", cur(), mk(8'h36, 8'h07, 0, 1, 0, 0, 0));
        chk("t2_ready_issue", byte_ready, 0);
        tick();
        chk("t2_ready_back", byte_ready, 1);
        chk("t2_valid_gone", insn_valid, 0);

        // 3: back-pressure holds the bundle stable and blocks fetch
        do_reset();
        send(8'h11);
        send(8'h12);
        send(8'h34);
        byte_valid = 1'b1;
        byte_data  = 8'h99;
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold", cur(), mk(8'h11, 8'h12, 8'h34, 2, 0, 0, 0));
            chk("t3_valid", insn_valid, 1);
            chk("t3_ready", byte_ready, 0);
            tick();
        end
        byte_valid = 1'b0;
        accept();
        chk("t3_issued", issued_cnt, 1);
        chk("t3_valid_gone", insn_valid, 0);
        send(8'h60);
        chk("t3_next_pc", cur(), mk(8'h60, 0, 0, 0, 0, 0, 3));
        accept();

        // 4: unsupported opcode then a normal one
        do_reset();
        send(8'hFF);
        chk("t4_unsup_b", cur(), mk(8'hFF, 0, 0, 0, 1, 0, 0));
        accept();
        chk("t4_unsup_cnt", unsup_cnt, 1);
        send(8'h60);
        chk("t4_iadd_b", cur(), mk(8'h60, 0, 0, 0, 0, 0, 1));
        accept();
        chk("t4_issued", issued_cnt, 2);
        chk("t4_unsup_cnt2", unsup_cnt, 1);

        // 5: reset in the middle of a goto (counters still hold test 4 values)
        send(8'hA7);
        send(8'h00);
        reset_n = 1'b0;
        #2;
        chk("t5_ready", byte_ready, 0);
        chk("t5_valid", insn_valid, 0);
        chk("t5_bundle", cur(), 0);
        chk("t5_issued", issued_cnt, 0);
        chk("t5_unsup", unsup_cnt, 0);
        tick();
        reset_n = 1'b1;
        tick();
        send(8'h03);
        chk("t5_after", cur(), mk(8'h03, 0, 0, 0, 0, 0, 0));
        accept();

        // 6: wide prefix
        do_reset();
`ifdef JAA_WIDE_EN
        send(8'hC4);
        chk("t6_no_issue", insn_valid, 0);
        send(8'h15);
        send(8'h01);
        send(8'h02);
        chk("t6_wide_b", cur(), mk(8'h15, 8'h01, 8'h02, 2, 0, 1, 0));
        accept();
        send(8'h60);
        chk("t6_next", cur(), mk(8'h60, 0, 0, 0, 0, 0, 4));
        accept();
`else
        send(8'hC4);
        chk("t6_c4_unsup", cur(), mk(8'hC4, 0, 0, 0, 1, 0, 0));
        accept();
        send(8'h60);
        chk("t6_next", cur(), mk(8'h60, 0, 0, 0, 0, 0, 1));
        accept();
`endif

        // randomized stream against the reference parser
        picks = '{8'h03, 8'h3C, 8'h60, 8'h5A, 8'h10, 8'h15, 8'h36, 8'h11, 8'hA7, 8'hFF, 8'hC4, 8'h1B};
        for (int k = 0; k < N; k++)
            stream[k] = ($urandom_range(9) < 7) ? picks[$urandom_range(11)] : 8'($urandom);
        i = 0;
        while (i < N) begin
            pc0 = i;
            w   = 1'b0;
            op  = stream[i];
`ifdef JAA_WIDE_EN
            if (op == 8'hC4) begin
                w = 1'b1;
                i++;
                if (i >= N) break;
                op = stream[i];
            end
`endif
            ref_len(op, w, ln, un);
            if (i + ln >= N) break;
            eb.op    = op;
            eb.o1    = (ln >= 1) ? stream[i+1] : 8'd0;
            eb.o2    = (ln == 2) ? stream[i+2] : 8'd0;
            eb.len   = 2'(ln);
            eb.unsup = un;
            eb.wide  = w;
            eb.pc    = pc0[PC_W-1:0];
            exp_q.push_back(eb);
            i += ln + 1;
        end

        do_reset();
        ei = 0; bi = 0; cyc = 0; acc = 0; uacc = 0;
        while (ei < exp_q.size() && cyc < 20000) begin
            byte_valid = (bi < N) && ($urandom_range(3) != 0);
            byte_data  = byte_valid ? stream[bi] : 8'($urandom);
            insn_ready = ($urandom_range(2) != 0);
            if (insn_valid) chk("rnd_exclusive", byte_ready, 0);
            if (insn_valid && insn_ready) begin
                chk("rnd_bundle", cur(), 64'(exp_q[ei]));
                acc++;
                if (exp_q[ei].unsup) uacc++;
                ei++;
            end
            if (byte_valid && byte_ready) bi++;
            tick();
            cyc++;
            chk("rnd_issued", issued_cnt, (acc > CMAX) ? CMAX : acc);
            chk("rnd_unsup", unsup_cnt, (uacc > CMAX) ? CMAX : uacc);
        end
        chk("rnd_all_bundles", ei, exp_q.size());
        byte_valid = 1'b0;
        insn_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
